dc_decode_controller: RTL
=========================

# dc_decode_controller

Sequences the combinational DC Huffman lookup table for one image component during baseline JPEG entropy decoding. It consumes the entropy-coded stream one bit per handshake and grows a candidate code word until the table reports a match. It then collects the `r_value` amplitude bits, converts them to a signed DC difference, and adds that difference to the running DC predictor. It sits between the bitstream unpacker and the coefficient buffer. The table stays a separate instance and is driven through the `tbl_*` ports.

## Interface
Parameters:
- `DC_W`, 12: width of signed DC difference, predictor and output value.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `bit_in` in 1: next stream bit, first-in = MSB.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: the controller accepts `bit_in` this cycle. A bit transfers when `bit_valid && bit_ready`.
- `tbl_bit_series` out [0:15]: candidate code. Index 0 holds the first received bit. Positions at or above `tbl_length` are 0.
- `tbl_length` out 5: number of code bits held, 0..16.
- `tbl_s_value` in 4: table run field. Ignored for DC; must be 0.
- `tbl_r_value` in 4: amplitude size, 0..11.
- `tbl_is_valid` in 1: the `(tbl_bit_series, tbl_length)` pair is a legal code.
- `dc_valid` out 1: decoded result is available.
- `dc_ready` in 1: consumer takes the result.
- `dc_value` out DC_W, signed: predictor + difference.
- `dc_diff` out DC_W, signed: decoded difference.
- `dc_size` out 4: `r_value` of the decoded symbol.
- `pred_clear` in 1: zero the predictor (restart marker, new scan).
- `err` out 1: no code matched within 16 bits.
- `err_clear` in 1: leave the error state.

## Operation
States: CODE, AMP, OUT, ERR. Reset state is CODE with `tbl_length` = 0.

CODE
- `bit_ready` = !tbl_is_valid && tbl_length != 16. The lookup always uses the registered code and length.
- Accepted bit: stored at index `tbl_length`, then `tbl_length` increments.
- `tbl_is_valid` = 1 and `tbl_r_value` = 0: next state OUT with `dc_diff` = 0 and `dc_size` = 0.
- `tbl_is_valid` = 1 and `tbl_r_value` > 0: latch r, clear amp register and count, next state AMP.
- `tbl_r_value` > 11 or `tbl_s_value` != 0 with `tbl_is_valid`: next state ERR.
- `tbl_length` = 16 and !tbl_is_valid: next state ERR.

AMP
- `bit_ready` = 1.
- Each accepted bit shifts into an 11-bit amp register, MSB first; count increments.
- On the r-th accepted bit, the diff is registered as follows:
  - amp MSB = 1: diff = amp.
  - amp MSB = 0: diff = amp − 2^r + 1, computed and sign-extended to DC_W.
- On the same edge, the registered `dc_value` = pred + diff, truncated to DC_W (two's-complement wrap). Next state OUT.

OUT
- `dc_valid` = 1 and `bit_ready` = 0. Outputs are held stable until `dc_ready`.
- On the handshake:
  - pred ← `dc_value`.
  - Code register and `tbl_length` clear to 0.
  - Next state CODE.

ERR
- `err` = 1, `bit_ready` = 0, `dc_valid` = 0.
- `err_clear` returns to CODE with `tbl_length` = 0. The predictor is kept.

`pred_clear` is honoured in any state and sets pred to 0 next edge. If it coincides with the OUT handshake, clear wins (pred = 0). `dc_value` already presented is unaffected.

## Timing
- Reset values:
  - `bit_ready` = 0 while `rst` is high.
  - `dc_valid` = 0, `err` = 0.
  - `dc_value`, `dc_diff`, `dc_size` = 0.
  - `tbl_bit_series` = 0, `tbl_length` = 0.
  - pred = 0, state CODE.
- `rst` mid-decode: partial code, amplitude and predictor are discarded. `bit_ready` = 1 in the first cycle after `rst` deasserts.
- Latency (last code bit accepted in cycle N):
  - Match is evaluated in N+1.
  - r = 0: `dc_valid` rises in N+2.
  - r > 0: AMP is entered in N+2. With back-to-back bits the last amp bit is accepted in N+1+r, and `dc_valid` rises in N+2+r.
- Throughput: one lookup bubble cycle per symbol plus one OUT cycle minimum.
- `bit_valid` low stalls CODE and AMP without losing state.
- `dc_ready` low holds OUT indefinitely.

## Test plan
- Basic r = 0 symbol: after reset, bits 0,0 → `dc_valid` with `dc_size` = 0, `dc_diff` = 0, `dc_value` = 0, asserted two cycles after the second bit.
- Predictor accumulation: stream 010,1 then 011,01 then 100,000 →
  - `dc_diff` = +1, −2, −7.
  - `dc_value` = 1, −1, −8.
- Largest size: code 111111110 + amp 10000000000 → `dc_size` = 11, `dc_diff` = 1024. Then code 111111110 + amp 00000000000 → `dc_diff` = −2047, `dc_value` = −1023.
- Invalid code: sixteen 1 bits → `err` = 1 after `tbl_length` reaches 16; `bit_ready` = 0. `err_clear` then code 00 → `dc_value` equals the predictor held before the error.
- Backpressure:
  - `bit_valid` toggles randomly during CODE and AMP; `dc_ready` is held low 5 cycles in OUT.
  - Required: outputs stay stable and `bit_ready` = 0 during the hold; results match the unstalled run.
- Clear/reset:
  - `pred_clear` coincident with the OUT handshake → next symbol 010,1 gives `dc_value` = 1.
  - `rst` asserted mid-AMP → state CODE, pred = 0, no `dc_valid`.

Source files
------------

// File: rtl/dc_decode_controller_if.sv
// Bundle between the DC decode controller, its bit source, the external DC
// Huffman table and the coefficient consumer.
interface dc_decode_controller_if #(
  parameter int DC_W = 12
) ();
  logic                   bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic [0:15]            tbl_bit_series;
  logic [4:0]             tbl_length;
  logic [3:0]             tbl_s_value;
  logic [3:0]             tbl_r_value;
  logic                   tbl_is_valid;
  logic                   dc_valid;
  logic                   dc_ready;
  logic signed [DC_W-1:0] dc_value;
  logic signed [DC_W-1:0] dc_diff;
  logic [3:0]             dc_size;
  logic                   pred_clear;
  logic                   err;
  logic                   err_clear;

  modport master (
    input  bit_in, bit_valid, tbl_s_value, tbl_r_value, tbl_is_valid,
           dc_ready, pred_clear, err_clear,
    output bit_ready, tbl_bit_series, tbl_length, dc_valid, dc_value,
           dc_diff, dc_size, err
  );

  modport slave (
    output bit_in, bit_valid, tbl_s_value, tbl_r_value, tbl_is_valid,
           dc_ready, pred_clear, err_clear,
    input  bit_ready, tbl_bit_series, tbl_length, dc_valid, dc_value,
           dc_diff, dc_size, err
  );
endinterface

// File: rtl/dc_decode_controller.sv
// DC coefficient decode sequencer: grows a Huffman code bit by bit against an
// external table, gathers the amplitude bits and accumulates the DC predictor.
module dc_decode_controller #(
  parameter int DC_W = 12
) (
  input logic              clk,
  input logic              rst,
  dc_decode_controller_if.master bus
);

  typedef enum logic [1:0] {CODE, AMP, OUT, ERR} state_t;

  state_t                 state;
  logic [0:15]            code_q;
  logic [4:0]             len_q;
  logic [3:0]             r_q;
  logic [3:0]             cnt_q;
  logic [10:0]            amp_q;
  logic signed [DC_W-1:0] pred_q;
  logic signed [DC_W-1:0] diff_q;
  logic signed [DC_W-1:0] value_q;
  logic [3:0]             size_q;
  logic                   valid_q;
  logic                   err_q;

  logic                   ready;
  logic                   take;
  logic                   len_full;
  logic                   tbl_bad;
  logic [10:0]            amp_nxt;
  logic [3:0]             cnt_nxt;
  logic                   amp_done;
  logic [10:0]            top_bit;
  logic                   amp_neg;
  logic signed [DC_W-1:0] amp_ext;
  logic signed [DC_W-1:0] diff_nxt;

  always_comb begin
    len_full = (len_q == 5'd16);
    tbl_bad  = bus.tbl_is_valid &&
               ((bus.tbl_r_value > 4'd11) || (bus.tbl_s_value != 4'd0));
    case (state)
      CODE:    ready = !bus.tbl_is_valid && !len_full;
      AMP:     ready = 1'b1;
      default: ready = 1'b0;
    endcase
    if (rst) ready = 1'b0;
  end

  assign take = bus.bit_valid && ready;

  // Amplitude decode: a leading 0 marks a negative value, offset by 2^r - 1.
  always_comb begin
    amp_nxt  = {amp_q[9:0], bus.bit_in};
    cnt_nxt  = cnt_q + 4'd1;
    amp_done = (cnt_nxt == r_q);
    top_bit  = 11'd1 << (r_q - 4'd1);
    amp_neg  = ~|(amp_nxt & top_bit);
    amp_ext  = DC_W'(amp_nxt);
    if (amp_neg) diff_nxt = amp_ext - (DC_W'(top_bit) << 1) + DC_W'(1);
    else         diff_nxt = amp_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CODE;
      code_q  <= '0;
      len_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      amp_q   <= '0;
      pred_q  <= '0;
      diff_q  <= '0;
      value_q <= '0;
      size_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        CODE: begin
          if (tbl_bad) begin
            err_q <= 1'b1;
            state <= ERR;
          end else if (bus.tbl_is_valid) begin
            if (bus.tbl_r_value == 4'd0) begin
              diff_q  <= '0;
              size_q  <= '0;
              value_q <= pred_q;
              valid_q <= 1'b1;
              state   <= OUT;
            end else begin
              r_q   <= bus.tbl_r_value;
              amp_q <= '0;
              cnt_q <= '0;
              state <= AMP;
            end
          end else if (len_full) begin
            err_q <= 1'b1;
            state <= ERR;
          end else if (take) begin
            code_q[len_q[3:0]] <= bus.bit_in;
            len_q              <= len_q + 5'd1;
          end
        end
        AMP: begin
          if (take) begin
            amp_q <= amp_nxt;
            cnt_q <= cnt_nxt;
            if (amp_done) begin
              diff_q  <= diff_nxt;
              size_q  <= r_q;
              value_q <= pred_q + diff_nxt;
              valid_q <= 1'b1;
              state   <= OUT;
            end
          end
        end
        OUT: begin
          if (bus.dc_ready) begin
            pred_q  <= value_q;
            code_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            state   <= CODE;
          end
        end
        ERR: begin
          if (bus.err_clear) begin
            code_q <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
            state  <= CODE;
          end
        end
        default: state <= CODE;
      endcase
      // Clear takes priority over the handshake's predictor update.
      if (bus.pred_clear) pred_q <= '0;
    end
  end

  assign bus.bit_ready      = ready;
  assign bus.tbl_bit_series = code_q;
  assign bus.tbl_length     = len_q;
  assign bus.dc_valid       = valid_q;
  assign bus.dc_value       = value_q;
  assign bus.dc_diff        = diff_q;
  assign bus.dc_size        = size_q;
  assign bus.err            = err_q;

endmodule
